// File: rtl/decoder_pkg.sv
// Shared constants and state encoding for the sequenced pulse decoder.
package decoder_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam int         CNT_W     = 8;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ACTIVE = ST_ACTIVE,
    S_GAP    = ST_GAP
  } state_e;
endpackage

// File: rtl/bin2onehot.sv
// Combinational binary-to-one-hot decoder; every code maps to exactly one line.
module bin2onehot #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 2**IN_W
) (
  input  logic [IN_W-1:0]  i_code,
  output logic [OUT_W-1:0] o_onehot
);
  // Clear all lines, then raise the indexed one.
  always_comb begin
    o_onehot         = '0;
    o_onehot[i_code] = 1'b1;
  end
endmodule

// File: rtl/pulse_decoder.sv
// Accepts a line index over valid/ready and drives its one-hot line for PULSE_LEN cycles,
// with a one-deep pending slot and GAP_LEN idle cycles between pulses.
module pulse_decoder
  import decoder_pkg::*;
#(
  parameter int IN_W      = 3,
  parameter int OUT_W     = 2**IN_W,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  code,
  output logic [OUT_W-1:0] y,
  output logic             busy,
  output logic             done
);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);

  state_e            r_state, w_nxt_state;
  logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
  logic [OUT_W-1:0]  r_y, w_nxt_y;
  logic              r_done, w_nxt_done;
  logic              r_pend_full, w_nxt_pend_full;
  logic [IN_W-1:0]   r_pend_code, w_nxt_pend_code;
  logic [OUT_W-1:0]  w_code_oh, w_pend_oh;
  logic              w_accept;

  bin2onehot #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dec_code (.i_code(code),        .o_onehot(w_code_oh));
  bin2onehot #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dec_pend (.i_code(r_pend_code), .o_onehot(w_pend_oh));

  assign in_ready = enable && !r_pend_full;
  assign w_accept = in_valid && in_ready;
  assign busy     = (r_state != S_IDLE) || r_pend_full;
  assign y        = r_y;
  assign done     = r_done;

  // Next-state, counter, output line and pending-slot logic.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_y         = r_y;
    w_nxt_pend_full = r_pend_full;
    w_nxt_pend_code = r_pend_code;
    if (!enable) begin
      w_nxt_state     = S_IDLE;
      w_nxt_cnt       = CNT_ZERO;
      w_nxt_y         = '0;
      w_nxt_pend_full = 1'b0;
      w_nxt_pend_code = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_nxt_state = S_ACTIVE;
            w_nxt_cnt   = PULSE_LOAD;
            w_nxt_y     = w_code_oh;
          end else begin
            w_nxt_cnt = CNT_ZERO;
            w_nxt_y   = '0;
          end
        end
        S_ACTIVE: begin
          if (r_cnt != CNT_ZERO) begin
            w_nxt_cnt = r_cnt - CNT_ONE;
            if (w_accept) begin
              w_nxt_pend_full = 1'b1;
              w_nxt_pend_code = code;
            end else begin
              w_nxt_pend_full = r_pend_full;
            end
          end else if (GAP_LEN > 0) begin
            w_nxt_state = S_GAP;
            w_nxt_cnt   = GAP_LOAD;
            w_nxt_y     = '0;
            if (w_accept) begin
              w_nxt_pend_full = 1'b1;
              w_nxt_pend_code = code;
            end else begin
              w_nxt_pend_full = r_pend_full;
            end
          end else if (r_pend_full) begin
            w_nxt_cnt       = PULSE_LOAD;
            w_nxt_y         = w_pend_oh;
            w_nxt_pend_full = 1'b0;
          end else if (w_accept) begin
            // Zero gap with an empty slot: the new code goes straight to the line.
            w_nxt_cnt = PULSE_LOAD;
            w_nxt_y   = w_code_oh;
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_y     = '0;
          end
        end
        S_GAP: begin
          w_nxt_y = '0;
          if (r_cnt != CNT_ZERO) begin
            w_nxt_cnt = r_cnt - CNT_ONE;
            if (w_accept) begin
              w_nxt_pend_full = 1'b1;
              w_nxt_pend_code = code;
            end else begin
              w_nxt_pend_full = r_pend_full;
            end
          end else if (r_pend_full) begin
            w_nxt_state     = S_ACTIVE;
            w_nxt_cnt       = PULSE_LOAD;
            w_nxt_y         = w_pend_oh;
            w_nxt_pend_full = 1'b0;
          end else if (w_accept) begin
            w_nxt_state = S_ACTIVE;
            w_nxt_cnt   = PULSE_LOAD;
            w_nxt_y     = w_code_oh;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end
        default: begin
          w_nxt_state     = S_IDLE;
          w_nxt_cnt       = CNT_ZERO;
          w_nxt_y         = '0;
          w_nxt_pend_full = 1'b0;
          w_nxt_pend_code = '0;
        end
      endcase
    end
    // done is registered, so it is raised on entry to the final ACTIVE cycle.
    w_nxt_done = (w_nxt_state == S_ACTIVE) && (w_nxt_cnt == CNT_ZERO);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= CNT_ZERO;
      r_y         <= '0;
      r_done      <= 1'b0;
      r_pend_full <= 1'b0;
      r_pend_code <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_y         <= w_nxt_y;
      r_done      <= w_nxt_done;
      r_pend_full <= w_nxt_pend_full;
      r_pend_code <= w_nxt_pend_code;
    end
  end
endmodule

// File: tb/tb_pulse_decoder.sv
// Directed bench for pulse_decoder: default instance (PULSE_LEN=4, GAP_LEN=1)
// and a second instance with PULSE_LEN=1, GAP_LEN=0.
module tb_pulse_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       in_valid = 1'b0, in_valid2 = 1'b0;
  logic [2:0] code = 3'd0, code2 = 3'd0;
  logic       in_ready, in_ready2, busy, busy2, done, done2;
  logic [7:0] y, y2;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  pulse_decoder #(.IN_W(3), .OUT_W(8), .PULSE_LEN(4), .GAP_LEN(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .y(y), .busy(busy), .done(done)
  );

  pulse_decoder #(.IN_W(3), .OUT_W(8), .PULSE_LEN(1), .GAP_LEN(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid2), .in_ready(in_ready2),
    .code(code2), .y(y2), .busy(busy2), .done(done2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
    #3;
    n_tests++; if (y !== 8'h00 || y2 !== 8'h00) begin n_fail++; $display("FAIL reset_y got %h/%h want 00", y, y2); end
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_done_busy got %b%b want 00", done, busy); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", in_ready); end
    step();
    rst_n = 1'b1;
    step();
    n_tests++; if (y !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset got y=%h busy=%b rdy=%b want 00/0/1", y, busy, in_ready); end
  endtask

  task automatic test_single();
    logic [7:0] ey [7] = '{8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
    logic       ed [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      in_valid = (i == 0); code = 3'd5;
      n_tests++; if (y !== ey[i]) begin n_fail++; $display("FAIL single_y c=%0d got %h want %h", i, y, ey[i]); end
      n_tests++; if (done !== ed[i]) begin n_fail++; $display("FAIL single_done c=%0d got %b want %b", i, done, ed[i]); end
      step();
    end
    in_valid = 1'b0;
    n_tests++; if (busy !== 1'b0 || y !== 8'h00) begin n_fail++; $display("FAIL single_end got busy=%b y=%h want 0/00", busy, y); end
  endtask

  task automatic test_pending();
    logic       v  [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] c  [12] = '{3'd2, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [7:0] ey [12] = '{8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 8'h00};
    logic       er [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       ed [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      in_valid = v[i]; code = c[i];
      n_tests++; if (y !== ey[i]) begin n_fail++; $display("FAIL pend_y c=%0d got %h want %h", i, y, ey[i]); end
      n_tests++; if (in_ready !== er[i]) begin n_fail++; $display("FAIL pend_ready c=%0d got %b want %b", i, in_ready, er[i]); end
      n_tests++; if (done !== ed[i]) begin n_fail++; $display("FAIL pend_done c=%0d got %b want %b", i, done, ed[i]); end
      step();
    end
    in_valid = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pend_busy_end got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic       v  [17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] c  [17] = '{3'd1, 3'd4, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [7:0] ey [17] = '{8'h00, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00,
                            8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00};
    logic       er [17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       ed [17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 17; i++) begin
      in_valid = v[i]; code = c[i];
      n_tests++; if (y !== ey[i]) begin n_fail++; $display("FAIL b2b_y c=%0d got %h want %h", i, y, ey[i]); end
      n_tests++; if (in_ready !== er[i]) begin n_fail++; $display("FAIL b2b_ready c=%0d got %b want %b", i, in_ready, er[i]); end
      n_tests++; if (done !== ed[i]) begin n_fail++; $display("FAIL b2b_done c=%0d got %b want %b", i, done, ed[i]); end
      step();
    end
    in_valid = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end got %b want 0", busy); end
  endtask

  task automatic test_no_gap();
    logic       v  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] c  [4] = '{3'd0, 3'd3, 3'd0, 3'd0};
    logic [7:0] ey [4] = '{8'h00, 8'h01, 8'h08, 8'h00};
    logic       ed [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      in_valid2 = v[i]; code2 = c[i];
      n_tests++; if (y2 !== ey[i]) begin n_fail++; $display("FAIL nogap_y c=%0d got %h want %h", i, y2, ey[i]); end
      n_tests++; if (done2 !== ed[i]) begin n_fail++; $display("FAIL nogap_done c=%0d got %b want %b", i, done2, ed[i]); end
      n_tests++; if (in_ready2 !== 1'b1) begin n_fail++; $display("FAIL nogap_ready c=%0d got %b want 1", i, in_ready2); end
      step();
    end
    in_valid2 = 1'b0;
    n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL nogap_busy_end got %b want 0", busy2); end
  endtask

  task automatic test_enable_abort();
    in_valid = 1'b1; code = 3'd2;
    step();
    code = 3'd6;
    n_tests++; if (y !== 8'h04) begin n_fail++; $display("FAIL abort_first got %h want 04", y); end
    step();
    in_valid = 1'b0;
    n_tests++; if (y !== 8'h04 || busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_second got y=%h busy=%b rdy=%b want 04/1/0", y, busy, in_ready); end
    enable = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_low got %b want 0", in_ready); end
    step();
    n_tests++; if (y !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_idle got y=%h busy=%b rdy=%b done=%b want 00/0/0/0", y, busy, in_ready, done); end
    in_valid = 1'b1; code = 3'd3;
    step();
    n_tests++; if (y !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_disabled_req got y=%h busy=%b want 00/0", y, busy); end
    in_valid = 1'b0;
    enable = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_reenable_ready got %b want 1", in_ready); end
    for (int i = 0; i < 8; i++) begin
      step();
      n_tests++; if (y !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_stale c=%0d got y=%h busy=%b want 00/0", i, y, busy); end
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; code = 3'd7;
    step();
    in_valid = 1'b0;
    step();
    n_tests++; if (y !== 8'h80) begin n_fail++; $display("FAIL arst_pre got %h want 80", y); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (y !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_immediate got y=%h busy=%b want 00/0", y, busy); end
    step();
    rst_n = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1 || busy !== 1'b0 || y !== 8'h00) begin n_fail++; $display("FAIL arst_release got rdy=%b busy=%b y=%h want 1/0/00", in_ready, busy, y); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++; if (y !== 8'h00) begin n_fail++; $display("FAIL arst_after c=%0d got %h want 00", i, y); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pending();
    test_back_to_back();
    test_no_gap();
    test_enable_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
